poly_add_seq: RTL and testbench

Sequencer for whole-polynomial modular addition in the ML-KEM datapath. It reads coefficient pairs from two polynomial memories, streams them through an internal `mod_add` instance, and buffers the results in a small FIFO. It then writes them to a destination memory over a ready/valid write port. The block sits between the polynomial RAMs and `mod_add`, driving it and consuming its output, with a credit scheme that tolerates destination backpressure.

---
 rtl/poly_arith_pkg.sv | 17 +
 rtl/coeff_fifo.sv | 59 +++++
 rtl/mod_add.sv | 48 ++++
 rtl/poly_add_seq.sv | 139 +++++++++++++
 tb/tb_poly_add_seq.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/poly_arith_pkg.sv
// Shared types and constants for the ML-KEM polynomial arithmetic blocks.
package poly_arith_pkg;

  typedef logic [11:0] coeff_t;
  localparam coeff_t Q = 12'd3329;

  localparam int N_COEFF = 256;
  typedef logic [7:0] poly_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } poly_seq_state_e;

endpackage

// File: rtl/coeff_fifo.sv
// Small synchronous coefficient FIFO; head is read straight from registered storage.
module coeff_fifo
  import poly_arith_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  coeff_t                     push_data,
  input  logic                       pop,
  output coeff_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  coeff_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage and pointers; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged, even when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 1'b1;
    end else if (!push && pop) begin
      count <= count - 1'b1;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mod_add.sv
// Two-stage modular adder: operands registered, then (a + b) mod Q registered.
module mod_add
  import poly_arith_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   valid_i,
  input  coeff_t a_i,
  input  coeff_t b_i,
  output logic   valid_o,
  output coeff_t result_o
);

  logic        valid_q;
  coeff_t      a_q;
  coeff_t      b_q;
  logic [12:0] sum;

  // Stage 1: capture operands and their valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= valid_i;
      a_q     <= a_i;
      b_q     <= b_i;
    end
  end

  // Full-width sum; both operands are below Q so one conditional subtract reduces it.
  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
  end

  // Stage 2: reduced result and its valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o  <= valid_q;
      result_o <= (sum >= {1'b0, Q}) ? 12'(sum - {1'b0, Q}) : sum[11:0];
    end
  end

endmodule

// File: rtl/poly_add_seq.sv
// Whole-polynomial modular addition sequencer with credit-based read issue.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing reads while credit allows
// DRAIN | all reads issued, waiting for the final write handshake
// DONE  | one-cycle done_o pulse
module poly_add_seq
  import poly_arith_pkg::*;
#(
  parameter int N          = N_COEFF,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  coeff_t            rd_a_i,
  input  coeff_t            rd_b_i,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output coeff_t            wr_data_o
);

  localparam int              CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(N - 1);

  poly_seq_state_e  state;
  logic [ADDR_W:0]  issue_cnt;
  logic [ADDR_W:0]  wr_cnt;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rd_valid_q;
  logic             ma_valid;
  coeff_t           ma_result;
  logic             push;
  logic             pop;

  // Everything already issued but not yet written out holds a FIFO slot in reserve.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign rd_en_o     = (state == RUN) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign push        = ma_valid;
  assign pop         = wr_valid_o && wr_ready_i;
  assign wr_valid_o  = !fifo_empty;
  assign rd_addr_o   = issue_cnt[ADDR_W-1:0];
  assign wr_addr_o   = wr_cnt[ADDR_W-1:0];

  // Sequencer FSM with issue/write counters and registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      issue_cnt <= '0;
      wr_cnt    <= '0;
    end else begin
      if (rd_en_o) issue_cnt <= issue_cnt + 1'b1;
      if (pop)     wr_cnt    <= wr_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= RUN;
            busy_o    <= 1'b1;
            issue_cnt <= '0;
            wr_cnt    <= '0;
          end
        end
        RUN: begin
          if (rd_en_o && issue_cnt == LAST) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && wr_cnt == LAST) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM data arrives one cycle after the read strobe; align the adder's valid with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid_q <= 1'b0;
    else        rd_valid_q <= rd_en_o;
  end

  // Pairs issued to the RAMs that have not yet landed in the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (rd_en_o && !push) begin
      inflight <= inflight + 1'b1;
    end else if (!rd_en_o && push) begin
      inflight <= inflight - 1'b1;
    end
  end

  mod_add u_mod_add (
    .clk      (clk),
    .rst      (~rst_n),
    .valid_i  (rd_valid_q),
    .a_i      (rd_a_i),
    .b_i      (rd_b_i),
    .valid_o  (ma_valid),
    .result_o (ma_result)
  );

  coeff_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (ma_result),
    .pop       (pop),
    .head      (wr_data_o),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The credit scheme must never let a result arrive at a full FIFO that is not draining.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_poly_add_seq.sv
// Bench for poly_add_seq: source RAM models, a reference sum table and per-run scoreboards.
module tb_poly_add_seq;
  import poly_arith_pkg::*;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       start_i    = 1'b0;
  logic       wr_ready_i = 1'b1;
  logic       busy_o, done_o, rd_en_o, wr_valid_o;
  logic [7:0] rd_addr_o, wr_addr_o;
  coeff_t     rd_a_i = '0;
  coeff_t     rd_b_i = '0;
  coeff_t     wr_data_o;

  coeff_t mem_a [256];
  coeff_t mem_b [256];
  int     exp_d [256];

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int cyc    = 0;

  int k_r, hs, issued, bad_data, bad_addr, bad_rd, credit_bad, stab_bad;
  int done_n, done_at, busy_n, busy_first, first_valid, last_hs, max_out;
  logic [31:0] first_data;

  poly_add_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rd_en_o    (rd_en_o),
    .rd_addr_o  (rd_addr_o),
    .rd_a_i     (rd_a_i),
    .rd_b_i     (rd_b_i),
    .wr_valid_o (wr_valid_o),
    .wr_ready_i (wr_ready_i),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en_o) begin
      rd_a_i <= mem_a[rd_addr_o];
      rd_b_i <= mem_b[rd_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_busy"},     32'(busy_o),     32'd0);
    check({p, "_done"},     32'(done_o),     32'd0);
    check({p, "_rd_en"},    32'(rd_en_o),    32'd0);
    check({p, "_wr_valid"}, 32'(wr_valid_o), 32'd0);
    check({p, "_rd_addr"},  32'(rd_addr_o),  32'd0);
    check({p, "_wr_addr"},  32'(wr_addr_o),  32'd0);
    check({p, "_wr_data"},  32'(wr_data_o),  32'd0);
  endtask

  task automatic make_expected();
    for (int i = 0; i < 256; i++) exp_d[i] = (int'(mem_a[i]) + int'(mem_b[i])) % 3329;
  endtask

  task automatic load_linear();
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = coeff_t'(i % 3329);
      mem_b[i] = 12'd3328;
    end
    make_expected();
  endtask

  task automatic load_random(input bit corner);
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = coeff_t'($urandom_range(0, 3328));
      mem_b[i] = coeff_t'($urandom_range(0, 3328));
    end
    if (corner) begin
      mem_a[0] = 12'd3328;
      mem_b[0] = 12'd3328;
    end
    make_expected();
  endtask

  // mode 0: ready always high; 1: 20-cycle stall from k+10; 2: 30% random ready;
  // 3: ready high with extra start pulses during RUN and DRAIN. abort_at > 0 asserts reset in cycle k+abort_at.
  task automatic run_one(input int mode, input int abort_at);
    logic       pv, pr;
    logic [7:0] pa;
    coeff_t     pd;
    hs = 0; issued = 0; bad_data = 0; bad_addr = 0; bad_rd = 0; credit_bad = 0; stab_bad = 0;
    done_n = 0; done_at = 0; busy_n = 0; busy_first = -1; first_valid = -1; last_hs = -1; max_out = 0;
    first_data = '1;
    pv = 1'b0; pr = 1'b0; pa = '0; pd = '0;
    @(posedge clk); #1;
    start_i    = 1'b1;
    wr_ready_i = 1'b1;
    k_r        = cyc + 1;
    for (int c = k_r + 1; c <= k_r + 3000; c++) begin
      @(posedge clk); #1;
      start_i = (mode == 3) && (c == k_r + 50 || c == k_r + 258);
      case (mode)
        1:       wr_ready_i = !(c >= k_r + 10 && c <= k_r + 29);
        2:       wr_ready_i = ($urandom_range(0, 9) < 3);
        default: wr_ready_i = 1'b1;
      endcase
      if (abort_at > 0 && c == k_r + abort_at) begin
        rst_n = 1'b0;
        #1;
        break;
      end
      @(negedge clk);
      if (rd_en_o) begin
        if (issued - hs >= 8) credit_bad++;
        if (rd_addr_o !== 8'(issued % 256)) bad_rd++;
        issued++;
        if (issued - hs > max_out) max_out = issued - hs;
      end
      if (wr_valid_o && first_valid < 0) first_valid = c;
      if (pv && !pr && (wr_valid_o !== 1'b1 || wr_addr_o !== pa || wr_data_o !== pd)) stab_bad++;
      if (wr_valid_o && wr_ready_i) begin
        if (wr_addr_o !== 8'(hs % 256)) bad_addr++;
        if (wr_data_o !== coeff_t'(exp_d[hs % 256])) bad_data++;
        if (hs == 0) first_data = 32'(wr_data_o);
        hs++;
        last_hs = c;
      end
      pv = wr_valid_o; pr = wr_ready_i; pa = wr_addr_o; pd = wr_data_o;
      if (busy_o) begin
        busy_n++;
        if (busy_first < 0) busy_first = c;
      end
      if (done_o) begin
        done_n++;
        done_at = c;
      end
      if (done_n > 0 && c >= done_at + 2) break;
    end
    start_i    = 1'b0;
    wr_ready_i = 1'b1;
  endtask

  task automatic post_checks(input int mode);
    check("hs_count",    32'(hs),         32'd256);
    check("wr_data",     32'(bad_data),   32'd0);
    check("wr_addr_seq", 32'(bad_addr),   32'd0);
    check("rd_addr_seq", 32'(bad_rd),     32'd0);
    check("credit",      32'(credit_bad), 32'd0);
    check("wr_hold",     32'(stab_bad),   32'd0);
    check("done_count",  32'(done_n),     32'd1);
    check("busy_after",  32'(busy_o),     32'd0);
    if (mode == 0 || mode == 3) begin
      check("first_valid_cyc", 32'(first_valid - k_r), 32'd5);
      check("last_hs_cyc",     32'(last_hs - k_r),     32'd260);
      check("done_cyc",        32'(done_at - k_r),     32'd261);
      check("busy_first_cyc",  32'(busy_first - k_r),  32'd1);
      check("busy_len",        32'(busy_n),            32'd261);
    end
    if (mode == 1) begin
      check("max_outstanding",  32'(max_out),         32'd8);
      check("stall_last_hs",    32'(last_hs - k_r),   32'd280);
    end
  endtask

  initial begin
    load_linear();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_one(0, 0);
    post_checks(0);

    load_random(1'b1);
    run_one(1, 0);
    post_checks(1);
    check("corner_3328_3328", first_data, 32'd3327);

    load_random(1'b0);
    run_one(2, 0);
    post_checks(2);

    load_random(1'b1);
    run_one(3, 0);
    post_checks(3);
    check("corner_full_rate", first_data, 32'd3327);

    load_random(1'b0);
    run_one(0, 100);
    check_zero("abort");
    check("abort_busy_len", 32'(busy_n), 32'd99);
    check("abort_no_done",  32'(done_n), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_zero("abort_hold");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort_idle", 32'(busy_o), 32'd0);

    load_linear();
    run_one(0, 0);
    post_checks(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
